// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared glyph table, mode encodings and sizing helper for the console front panel
package console_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic MODE_CTRL = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hex_seg.sv
// rtl/hex_seg.sv - one seven-segment digit decoder with a blanking override
module hex_seg
  import console_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_GLYPH[nib_i];

endmodule

// File: rtl/console_iface.sv
// rtl/console_iface.sv - key debounce, switch capture into byte lanes / control word, registered hex display
module console_iface
  import console_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CTRL_W    = 9,
  parameter int SW_W      = 10,
  parameter int DIGITS    = 4,
  parameter int DB_CYCLES = 16,
  parameter int LZB       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_n,
  input  logic [SW_W-1:0]     sw,
  input  logic                z_in,
  input  logic [DATA_W-1:0]   disp_val,
  output logic [DATA_W-1:0]   datapath_in,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                dp_en,
  output logic [((clog2(DATA_W/8) < 1) ? 1 : clog2(DATA_W/8))-1:0] lane,
  output logic [SW_W-1:0]     led,
  output logic [7*DIGITS-1:0] hex
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (clog2(LANES) < 1) ? 1 : clog2(LANES);
  localparam int CNT_W  = clog2(DB_CYCLES + 1);
  localparam int NDIG   = DATA_W / 4;

  logic              sync1_q, sync2_q;
  logic              db_q, db_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_q, step_d;
  logic              dp_en_q, dp_en_d;
  logic [DATA_W-1:0] datapath_q, datapath_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic              mode;

  assign mode = sw[SW_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      db_q       <= 1'b1;
      cnt_q      <= '0;
      step_q     <= 1'b0;
      dp_en_q    <= 1'b0;
      datapath_q <= '0;
      ctrl_q     <= '0;
      lane_q     <= '0;
      hex_q      <= '1;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      dp_en_q    <= dp_en_d;
      datapath_q <= datapath_d;
      ctrl_q     <= ctrl_d;
      lane_q     <= lane_d;
      hex_q      <= hex_d;
    end
  end

  // Any cycle of agreement restarts the stability count
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) db_d = sync2_q;
      else                                cnt_d = cnt_q + CNT_W'(1);
    end
    step_d = db_q & ~db_d;
  end

  always_comb begin
    datapath_d = datapath_q;
    ctrl_d     = ctrl_q;
    lane_d     = lane_q;
    dp_en_d    = 1'b0;
    if (mode == MODE_CTRL) lane_d = '0;
    if (step_q) begin
      if (mode == MODE_DATA) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_q == LANE_W'(i)) datapath_d[8*i +: 8] = sw[7:0];
        end
        lane_d = (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + LANE_W'(1);
      end else begin
        ctrl_d  = sw[CTRL_W-1:0];
        dp_en_d = 1'b1;
      end
    end
  end

  assign led = {z_in, (mode == MODE_DATA) ? (SW_W-1)'(ctrl_q) : datapath_q[SW_W-2:0]};

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    if (k < NDIG) begin : g_on
      logic blank;
      assign blank = (LZB != 0) && (k > 0) && (disp_val[DATA_W-1:4*k] == '0);
      hex_seg u_seg (
        .nib_i   (disp_val[4*k +: 4]),
        .blank_i (blank),
        .seg_o   (hex_d[7*k +: 7])
      );
    end else begin : g_off
      assign hex_d[7*k +: 7] = SEG_BLANK;
    end
  end

  assign datapath_in = datapath_q;
  assign ctrl        = ctrl_q;
  assign dp_en       = dp_en_q;
  assign lane        = lane_q;
  assign hex         = hex_q;

endmodule

// File: tb/tb_console_iface.sv
// tb/tb_console_iface.sv - directed self-checking bench for console_iface
module tb_console_iface;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 9;
  localparam int SW_W   = 10;
  localparam int DIGITS = 6;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                key_n;
  logic [SW_W-1:0]     sw;
  logic                z_in;
  logic [DATA_W-1:0]   disp_val;
  logic [DATA_W-1:0]   datapath_in;
  logic [CTRL_W-1:0]   ctrl;
  logic                dp_en;
  logic [0:0]          lane;
  logic [SW_W-1:0]     led;
  logic [7*DIGITS-1:0] hex;

  console_iface #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SW_W(SW_W),
    .DIGITS(DIGITS), .DB_CYCLES(16), .LZB(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw(sw), .z_in(z_in),
    .disp_val(disp_val), .datapath_in(datapath_in), .ctrl(ctrl),
    .dp_en(dp_en), .lane(lane), .led(led), .hex(hex)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int dp_pulses = 0;

  always @(posedge clk) begin
    #1;
    if (dp_en === 1'b1) dp_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step_key();
    @(negedge clk); key_n = 1'b0;
    repeat (25) @(negedge clk);
    key_n = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  // Counts negedges from the current key level change; returns the first one showing dp_en
  task automatic measure_first(output int first, output logic [8:0] c18,
                               output logic [8:0] c19, output logic dp20);
    first = 0; c18 = '0; c19 = '0; dp20 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk); #1;
      if (dp_en === 1'b1 && first == 0) first = n;
      if (n == 18) c18 = ctrl;
      if (n == 19) c19 = ctrl;
      if (n == 20) dp20 = dp_en;
    end
  endtask

  localparam logic [6:0] BL = 7'h7F;

  initial begin
    int p0, first;
    logic [8:0] c18, c19;
    logic dp20;

    rst_n = 1'b0; key_n = 1'b1; sw = '0; z_in = 1'b0; disp_val = '0;
    repeat (3) @(negedge clk);
    check("rst_datapath", datapath_in, 16'h0000);
    check("rst_ctrl", ctrl, 9'h000);
    check("rst_lane", lane, 1'b0);
    check("rst_dp_en", dp_en, 1'b0);
    check("rst_hex", hex, {42{1'b1}});
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("hex_zero_lzb", hex, {BL, BL, BL, BL, BL, 7'h40});

    // Data lanes
    p0 = dp_pulses;
    sw = 10'h234;
    step_key();
    check("data1_dp", datapath_in, 16'h0034);
    check("data1_lane", lane, 1'b1);
    sw = 10'h212;
    step_key();
    check("data2_dp", datapath_in, 16'h1234);
    check("data2_lane", lane, 1'b0);
    sw = 10'h2AB;
    step_key();
    check("data3_dp", datapath_in, 16'h12AB);
    check("data3_lane", lane, 1'b1);
    check("data_led", led, 10'h000);
    check("data_no_dp_en", dp_pulses - p0, 0);

    // Control word
    sw = 10'h0A5;
    @(negedge clk); #1;
    check("ctrl_lane_forced", lane, 1'b0);
    p0 = dp_pulses;
    key_n = 1'b0;
    measure_first(first, c18, c19, dp20);
    check("ctrl_latency", first, 19);
    check("ctrl_before", c18, 9'h000);
    check("ctrl_after", c19, 9'h0A5);
    check("ctrl_dp_one_cycle", dp20, 1'b0);
    check("ctrl_lane", lane, 1'b0);
    check("ctrl_led", led, 10'h0AB);
    key_n = 1'b1;
    repeat (30) @(negedge clk);
    check("ctrl_single_pulse", dp_pulses - p0, 1);

    // Bounce: 13 toggles every 3 cycles, ending low and held
    p0 = dp_pulses;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) repeat (3) @(negedge clk);
      key_n = ~key_n;
    end
    check("bounce_no_early_step", dp_pulses - p0, 0);
    measure_first(first, c18, c19, dp20);
    check("bounce_latency", first, 19);
    check("bounce_one_step", dp_pulses - p0, 1);
    key_n = 1'b1;
    repeat (30) @(negedge clk);

    // Held key
    p0 = dp_pulses;
    key_n = 1'b0;
    repeat (1000) @(negedge clk);
    check("held_one_step", dp_pulses - p0, 1);
    z_in = 1'b1; #1;
    check("led_z1", led, 10'h2AB);
    z_in = 1'b0; #1;
    check("led_z0", led, 10'h0AB);
    key_n = 1'b1;
    repeat (30) @(negedge clk);
    sw = 10'h200; #1;
    check("led_data_mode_ctrl", led, 10'h0A5);

    // Display
    @(negedge clk);
    disp_val = 16'h00F0; #1;
    check("hex_latency", hex, {BL, BL, BL, BL, BL, 7'h40});
    @(negedge clk); #1;
    check("hex_00F0", hex, {BL, BL, BL, BL, 7'h0E, 7'h40});
    disp_val = 16'h1A03;
    @(negedge clk); #1;
    check("hex_1A03", hex, {BL, BL, 7'h79, 7'h08, 7'h40, 7'h30});

    // Reset with dp_en pending
    sw = 10'h1FF;
    @(negedge clk); key_n = 1'b0;
    repeat (18) @(negedge clk);
    p0 = dp_pulses;
    rst_n = 1'b0; key_n = 1'b1; #1;
    check("rst2_dp_en", dp_en, 1'b0);
    check("rst2_ctrl", ctrl, 9'h000);
    check("rst2_datapath", datapath_in, 16'h0000);
    check("rst2_lane", lane, 1'b0);
    check("rst2_hex", hex, {42{1'b1}});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst2_no_pulse", dp_pulses - p0, 0);
    check("rst2_ctrl_after", ctrl, 9'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
